mux2_arbiter: RTL and testbench
===============================

MUX2_ARBITER -- requirements
Module: mux2_arbiter

Interface
REQ-001 Parameter: WIDTH, 100, data width of each requester and of the output.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: a_valid  input  1  requester A presents a word.
REQ-005 Port: a_data  input  WIDTH  requester A word.
REQ-006 Port: a_ready  output  1  requester A word accepted this cycle.
REQ-007 Port: b_valid  input  1  requester B presents a word.
REQ-008 Port: b_data  input  WIDTH  requester B word.
REQ-009 Port: b_ready  output  1  requester B word accepted this cycle.
REQ-010 Port: sel  output  1  mux select; 0 = A, 1 = B, combinational grant for the current cycle.
REQ-011 Port: out_valid  output  1  output register holds a word.
REQ-012 Port: out_data  output  WIDTH  registered muxed word.
REQ-013 Port: out_src  output  1  source of the held word; 0 = A, 1 = B.
REQ-014 Port: out_ready  input  1  downstream consumes the held word when out_valid is high.

Function
REQ-015 The block SHALL contain a WIDTH-bit 2:1 mux: sel=0 selects a_data, sel=1 selects b_data.
REQ-016 FSM states SHALL be EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-017 load = (state==EMPTY) or (out_ready) SHALL be the only condition under which a word is accepted.
REQ-018 When only A is valid, sel SHALL be 0; when only B is valid, sel SHALL be 1; when neither is valid, sel SHALL hold last_grant.
REQ-019 When both are valid, sel SHALL be the arbitration winner (REQ-031/REQ-032).
REQ-020 a_ready = load and a_valid and sel==0; b_ready = load and b_valid and sel==1; never both high.
REQ-021 On an accepted word, out_data and out_src SHALL capture the selected data and sel at the same edge; latency is 1 cycle.
REQ-022 Transitions: EMPTY->FULL on accept; FULL->EMPTY on out_ready with no accept; FULL->FULL on out_ready with accept (back-to-back, full throughput) or on no out_ready (hold).
REQ-023 While FULL and out_ready=0, out_data and out_src SHALL remain stable and both ready outputs SHALL be 0.
REQ-024 A register last_grant SHALL update to sel on every accepted word only.
REQ-025 The ready outputs SHALL not depend on a_valid/b_valid of the other requester except through sel.

Reset
REQ-026 On reset, state SHALL go to EMPTY; out_valid=0, out_data=0, out_src=0.
REQ-027 On reset, last_grant SHALL be 1, so A wins the first contended cycle.
REQ-028 Reset asserted while FULL SHALL discard the held word; a_ready and b_ready SHALL be 0 during reset.
REQ-029 No word SHALL be accepted in the cycle reset is high.

Configuration
REQ-030 Macro MUX2_ARBITER_RR_EN selects the contention policy.
REQ-031 With MUX2_ARBITER_RR_EN defined: contention winner = ~last_grant (round-robin).
REQ-032 Without it: contention winner is always A (fixed priority); last_grant is still maintained.

Structure
REQ-033 Package mux2_arbiter_pkg SHALL hold the state enum (EMPTY, FULL), source constants SRC_A=0 / SRC_B=1, and default WIDTH=100.
REQ-034 The combinational mux SHALL be one sub-module, mux2_datapath (a, b, sel -> out, WIDTH-parameterised); the FSM and arbitration remain in mux2_arbiter.

Verification
REQ-035 Reset, then a_valid=1, a_data=all-ones, b_valid=0, out_ready=1 -> next cycle out_valid=1, out_data=all-ones, out_src=0.
REQ-036 Both valid, a_data=0xAAA..A, b_data=0x555..5, out_ready=1 for 4 cycles, RR_EN defined -> out_src sequence 0,1,0,1; without macro -> 0,0,0,0 and b_ready never high.
REQ-037 FULL with out_ready=0 for 3 cycles while both valid -> a_ready=b_ready=0, out_data unchanged; on out_ready=1, the next word loads in the same cycle.
REQ-038 Only B valid, b_data={50 ones, 50 zeros}, out_ready=1 -> sel=1, b_ready=1, out_data matches, out_src=1 one cycle later.
REQ-039 Assert reset while FULL holding 0x123 -> next cycle out_valid=0, out_data=0; first contended accept after reset is A.
REQ-040 Random a_data/b_data/valids/out_ready for 1000 cycles -> scoreboard: every accepted word appears exactly once, in order, with correct out_src; a_ready and b_ready never both high.

Source files
------------

// File: rtl/mux2_arbiter_pkg.sv
// Shared types and constants for the two-requester registered mux arbiter.
// The contention policy is selected at build time with MUX2_ARBITER_RR_EN.
package mux2_arbiter_pkg;

    localparam int unsigned DEFAULT_WIDTH = 100;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

endpackage

// File: rtl/mux2_datapath.sv
// WIDTH-bit 2:1 data mux; sel=0 picks a, sel=1 picks b.
module mux2_datapath #(
    parameter int unsigned WIDTH = 100
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    output logic [WIDTH-1:0] out
);

    assign out = sel ? b : a;

endmodule

// File: rtl/mux2_arbiter.sv
// Two-requester arbiter feeding a single registered output slot with valid/ready.
// Define MUX2_ARBITER_RR_EN for round-robin contention; otherwise A has fixed priority.
module mux2_arbiter
    import mux2_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_data,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [WIDTH-1:0] b_data,
    output logic             b_ready,
    output logic             sel,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_src,
    input  logic             out_ready
);

    state_t           r_state;
    logic             r_last_grant;
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_src;

    logic             w_winner;
    logic             w_sel;
    logic             w_load;
    logic             w_accept;
    logic [WIDTH-1:0] w_mux_data;

`ifdef MUX2_ARBITER_RR_EN
    assign w_winner = ~r_last_grant;
`else
    assign w_winner = SRC_A;
`endif

    // Grant: sole requester wins, contention uses the policy, idle holds last grant.
    always_comb begin
        w_sel = r_last_grant;
        if (a_valid && b_valid) begin
            w_sel = w_winner;
        end else if (a_valid) begin
            w_sel = SRC_A;
        end else if (b_valid) begin
            w_sel = SRC_B;
        end
    end

    // The slot can take a word when empty or when its current word drains this cycle.
    assign w_load   = !reset && ((r_state == EMPTY) || out_ready);
    assign a_ready  = w_load && a_valid && (w_sel == SRC_A);
    assign b_ready  = w_load && b_valid && (w_sel == SRC_B);
    assign w_accept = a_ready || b_ready;
    assign sel      = w_sel;

    mux2_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .a   (a_data),
        .b   (b_data),
        .sel (w_sel),
        .out (w_mux_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= EMPTY;
            r_last_grant <= SRC_B;
            r_out_data   <= '0;
            r_out_src    <= SRC_A;
        end else begin
            case (r_state)
                EMPTY: if (w_accept) r_state <= FULL;
                FULL:  if (out_ready && !w_accept) r_state <= EMPTY;
            endcase
            if (w_accept) begin
                r_out_data   <= w_mux_data;
                r_out_src    <= w_sel;
                r_last_grant <= w_sel;
            end
        end
    end

    assign out_valid = (r_state == FULL);
    assign out_data  = r_out_data;
    assign out_src   = r_out_src;

endmodule

// File: tb/tb_mux2_arbiter.sv
// Self-checking bench for mux2_arbiter: directed vector table, reset corner cases,
// and a randomized run checked against a cycle model with an output scoreboard.
module tb_mux2_arbiter;

    localparam int unsigned W = 100;
`ifdef MUX2_ARBITER_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    typedef struct {
        logic         av;
        logic [W-1:0] ad;
        logic         bv;
        logic [W-1:0] bd;
        logic         ordy;
        logic         e_sel;
        logic         e_ar;
        logic         e_br;
        logic         e_ov;
        logic         e_src;
    } vec_t;

    typedef struct {
        logic [W-1:0] data;
        logic         src;
    } word_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         a_valid = 1'b0;
    logic [W-1:0] a_data = '0;
    logic         a_ready;
    logic         b_valid = 1'b0;
    logic [W-1:0] b_data = '0;
    logic         b_ready;
    logic         sel;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_src;
    logic         out_ready = 1'b0;

    int    n_tests = 0;
    int    n_fail  = 0;
    word_t sb[$];
    vec_t  tab[$];
    logic  m_full = 1'b0;
    logic  m_last = 1'b1;

    mux2_arbiter #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .a_valid   (a_valid),
        .a_data    (a_data),
        .a_ready   (a_ready),
        .b_valid   (b_valid),
        .b_data    (b_data),
        .b_ready   (b_ready),
        .sel       (sel),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkw(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic av, input logic [W-1:0] ad, input logic bv,
                                input logic [W-1:0] bd, input logic ordy, input logic esel,
                                input logic ear, input logic ebr, input logic eov,
                                input logic esrc);
        vec_t v;
        v.av = av; v.ad = ad; v.bv = bv; v.bd = bd; v.ordy = ordy;
        v.e_sel = esel; v.e_ar = ear; v.e_br = ebr; v.e_ov = eov; v.e_src = esrc;
        return v;
    endfunction

    function automatic logic [W-1:0] rand_word();
        logic [127:0] r;
        r = {$urandom, $urandom, $urandom, $urandom};
        return r[W-1:0];
    endfunction

    // One cycle: drive, check grant/ready against model (and table), then check the slot.
    task automatic step(input vec_t v, input bit use_tab);
        logic  m_sel, m_load, m_ar, m_br;
        word_t w;
        @(negedge clk);
        a_valid = v.av; a_data = v.ad; b_valid = v.bv; b_data = v.bd; out_ready = v.ordy;
        #1;
        if (v.av && v.bv)      m_sel = RR ? ~m_last : 1'b0;
        else if (v.av)         m_sel = 1'b0;
        else if (v.bv)         m_sel = 1'b1;
        else                   m_sel = m_last;
        m_load = !m_full || v.ordy;
        m_ar   = m_load && v.av && !m_sel;
        m_br   = m_load && v.bv && m_sel;
        check1("sel", sel, m_sel);
        check1("a_ready", a_ready, m_ar);
        check1("b_ready", b_ready, m_br);
        check1("ready_exclusive", a_ready && b_ready, 1'b0);
        if (use_tab) begin
            check1("tab_sel", sel, v.e_sel);
            check1("tab_a_ready", a_ready, v.e_ar);
            check1("tab_b_ready", b_ready, v.e_br);
        end
        @(posedge clk);
        if (m_full && v.ordy && sb.size() > 0) void'(sb.pop_front());
        if (m_ar || m_br) begin
            w.data = m_sel ? v.bd : v.ad;
            w.src  = m_sel;
            sb.push_back(w);
            m_last = m_sel;
        end
        m_full = (m_ar || m_br) || (m_full && !v.ordy);
        #1;
        check1("out_valid", out_valid, m_full);
        if (m_full) begin
            if (sb.size() == 0) begin
                check1("scoreboard_nonempty", 1'b0, 1'b1);
            end else begin
                checkw("out_data", out_data, sb[0].data);
                check1("out_src", out_src, sb[0].src);
            end
        end
        if (use_tab) begin
            check1("tab_out_valid", out_valid, v.e_ov);
            if (v.e_ov) check1("tab_out_src", out_src, v.e_src);
        end
    endtask

    // Reset with optional live requests to show nothing is accepted while reset is high.
    task automatic do_reset(input bit hot);
        @(negedge clk);
        reset = 1'b1; a_valid = hot; b_valid = hot; out_ready = hot;
        a_data = rand_word(); b_data = rand_word();
        #1;
        check1("rst_a_ready", a_ready, 1'b0);
        check1("rst_b_ready", b_ready, 1'b0);
        @(posedge clk);
        #1;
        check1("rst_out_valid", out_valid, 1'b0);
        checkw("rst_out_data", out_data, '0);
        check1("rst_out_src", out_src, 1'b0);
        m_full = 1'b0; m_last = 1'b1; sb.delete();
        @(negedge clk);
        reset = 1'b0; a_valid = 1'b0; b_valid = 1'b0; out_ready = 1'b0;
    endtask

    initial begin
        logic [W-1:0] ones, aaa, five, half, w123;
        ones = '1;
        aaa  = {25{4'hA}};
        five = {25{4'h5}};
        half = {{50{1'b1}}, {50{1'b0}}};
        w123 = W'(12'h123);

        tab.push_back(mk(0, '0,   0, '0,   1, 1, 0, 0, 0, 0));
        for (int i = 0; i < 4; i++) begin
            logic s;
            s = RR ? 1'(i % 2) : 1'b0;
            tab.push_back(mk(1, aaa, 1, five, 1, s, !s, s, 1, s));
        end
        tab.push_back(mk(0, '0,   1, half, 1, 1, 0, 1, 1, 1));
        tab.push_back(mk(1, ones, 0, '0,   1, 0, 1, 0, 1, 0));
        tab.push_back(mk(0, '0,   0, '0,   1, 0, 0, 0, 0, 0));
        tab.push_back(mk(0, '0,   0, '0,   0, 0, 0, 0, 0, 0));
        tab.push_back(mk(0, '0,   1, five, 0, 1, 0, 1, 1, 1));
        for (int i = 0; i < 3; i++)
            tab.push_back(mk(1, aaa, 1, ones, 0, 0, 0, 0, 1, 1));
        tab.push_back(mk(1, aaa, 1, ones, 1, 0, 1, 0, 1, 0));
        tab.push_back(mk(0, '0,   0, '0,   1, 0, 0, 0, 0, 0));

        do_reset(1'b0);
        foreach (tab[i]) step(tab[i], 1'b1);

        // Reset while holding a word discards it; first contention afterwards goes to A.
        step(mk(1, w123, 0, '0, 0, 0, 1, 0, 1, 0), 1'b1);
        step(mk(0, '0,   0, '0, 0, 0, 0, 0, 1, 0), 1'b1);
        do_reset(1'b1);
        step(mk(1, aaa, 1, five, 1, 0, 1, 0, 1, 0), 1'b1);
        step(mk(0, '0,  0, '0,   1, 0, 0, 0, 0, 0), 1'b1);

        for (int i = 0; i < 1000; i++) begin
            vec_t v;
            v = mk(1'($urandom_range(0, 1)), rand_word(), 1'($urandom_range(0, 1)),
                   rand_word(), 1'($urandom_range(0, 3) != 0), 0, 0, 0, 0, 0);
            step(v, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
